// File: rtl/fe_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// fe_prefetch_pkg
// Shared constants for the instruction-fetch front end:
//   QISP_WORD_W   - native instruction word width
//   QISP_ADDR_W   - native word-addressed fetch address width
//   QISP_RESET_PC - default fetch PC after reset
//   clog2()       - constant ceil(log2(v)), used to size pointers and counters
// -----------------------------------------------------------------------------
package fe_prefetch_pkg;

  localparam int QISP_WORD_W = 16;
  localparam int QISP_ADDR_W = 16;
  localparam logic [QISP_ADDR_W-1:0] QISP_RESET_PC = '0;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fe_fifo.sv
// -----------------------------------------------------------------------------
// fe_fifo
// First-word-fall-through queue of DEPTH entries of W bits. The head entry is
// always presented on rd_data_o; count_o tells the consumer whether it is real.
//
// Ports:
//   clk, a_rst   - clock, asynchronous active-low reset
//   push_i       - write wr_data_i at the tail (ignored when full)
//   pop_i        - drop the head entry (ignored when empty)
//   flush_i      - empty the queue; overrides push_i and pop_i
//   wr_data_i    - tail write data
//   rd_data_o    - head entry (stale while count_o == 0)
//   count_o      - occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fe_fifo
  import fe_prefetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [W-1:0]          wr_data_i,
  output logic [W-1:0]          rd_data_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i & (count_q != DEPTH_C) & ~flush_i;
  assign pop_ok  = pop_i  & (count_q != '0)      & ~flush_i;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are only observable once count_q > 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fe_prefetch.sv
// -----------------------------------------------------------------------------
// fe_prefetch
// Prefetch queue between instruction memory and decode. Owns the fetch PC,
// requests words while the queue has room, tags each captured word with its
// address and presents the oldest one first-word-fall-through.
//
// Handshakes:
//   memory: a word is captured in any cycle where o_mem_req and i_mem_rdy are
//           both high; o_mem_adr holds until that happens.
//   decode: the head entry is consumed in any cycle where o_valid and i_take
//           are both high; i_take without o_valid does nothing.
//
// Ports:
//   clk, a_rst              - clock, asynchronous active-low reset
//   o_mem_adr, o_mem_req    - fetch address / request to memory
//   i_mem_rdy, i_mem_data   - memory returns the word for o_mem_adr
//   i_redirect, i_redirect_pc - flush and restart fetch at a new PC
//   i_halt                  - stop requesting until the next redirect
//   i_take                  - decode consumes the head entry
//   o_valid, o_ir, o_pc     - head entry and its address
//   o_count                 - occupied entries
//   o_halted                - sticky halt state
// -----------------------------------------------------------------------------
module fe_prefetch
  import fe_prefetch_pkg::*;
#(
  parameter int                 DATA_W   = QISP_WORD_W,
  parameter int                 ADDR_W   = QISP_ADDR_W,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(QISP_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  output logic [ADDR_W-1:0]     o_mem_adr,
  output logic                  o_mem_req,
  input  logic                  i_mem_rdy,
  input  logic [DATA_W-1:0]     i_mem_data,
  input  logic                  i_redirect,
  input  logic [ADDR_W-1:0]     i_redirect_pc,
  input  logic                  i_halt,
  input  logic                  i_take,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_ir,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [clog2(DEPTH):0] o_count,
  output logic                  o_halted
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              started_q;
  logic [CW-1:0]     count;
  logic [EW-1:0]     rd_entry;
  logic              mem_req;
  logic              push;
  logic              pop;

  // A full queue blocks the request even when decode pops in the same cycle;
  // the freed slot is only seen through the registered count next cycle.
  assign mem_req = started_q & ~halted_q & ~i_redirect & (count != DEPTH_C);
  assign push    = mem_req & i_mem_rdy;
  assign pop     = (count != '0) & i_take & ~i_redirect;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      halted_d = 1'b0;
    end else begin
      if (push)   pc_d     = pc_q + 1'b1;
      if (i_halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      started_q <= 1'b1;
    end
  end

  fe_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .a_rst     (a_rst),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (i_redirect),
    .wr_data_i ({pc_q, i_mem_data}),
    .rd_data_o (rd_entry),
    .count_o   (count)
  );

  assign o_mem_adr = pc_q;
  assign o_mem_req = mem_req;
  assign o_valid   = (count != '0);
  assign o_pc      = rd_entry[EW-1:DATA_W];
  assign o_ir      = rd_entry[DATA_W-1:0];
  assign o_count   = count;
  assign o_halted  = halted_q;

endmodule

// File: tb/tb_fe_prefetch.sv
// -----------------------------------------------------------------------------
// tb_fe_prefetch
// Directed bench for fe_prefetch at DEPTH=4. Memory returns word(addr) for the
// requested address; every expected value below is written out by hand.
// -----------------------------------------------------------------------------
module tb_fe_prefetch;

  logic        clk;
  logic        a_rst;
  logic [15:0] o_mem_adr;
  logic        o_mem_req;
  logic        i_mem_rdy;
  logic [15:0] i_mem_data;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt;
  logic        i_take;
  logic        o_valid;
  logic [15:0] o_ir;
  logic [15:0] o_pc;
  logic [2:0]  o_count;
  logic        o_halted;

  int checks;
  int errors;

  fe_prefetch #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk           (clk),
    .a_rst         (a_rst),
    .o_mem_adr     (o_mem_adr),
    .o_mem_req     (o_mem_req),
    .i_mem_rdy     (i_mem_rdy),
    .i_mem_data    (i_mem_data),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .i_take        (i_take),
    .o_valid       (o_valid),
    .o_ir          (o_ir),
    .o_pc          (o_pc),
    .o_count       (o_count),
    .o_halted      (o_halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: a fixed, address-dependent instruction word
  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  assign i_mem_data = word(o_mem_adr);

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    a_rst         = 1'b0;
    i_mem_rdy     = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_halt        = 1'b0;
    i_take        = 1'b0;

    // reset state
    #2;
    check_eq("rst_valid",  {31'd0, o_valid},   32'd0);
    check_eq("rst_count",  {29'd0, o_count},   32'd0);
    check_eq("rst_req",    {31'd0, o_mem_req}, 32'd0);
    check_eq("rst_halted", {31'd0, o_halted},  32'd0);
    check_eq("rst_adr",    {16'd0, o_mem_adr}, 32'h0000);

    // release away from the edge; no request before the first edge
    #10;
    a_rst = 1'b1;
    #1;
    check_eq("pre_start_req", {31'd0, o_mem_req}, 32'd0);
    tick();

    // fill: requests at 0..3, then stop
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("fill_req", {31'd0, o_mem_req}, 32'd1);
      check_eq("fill_adr", {16'd0, o_mem_adr}, 32'(i));
      tick();
    end
    #1;
    check_eq("full_req",   {31'd0, o_mem_req}, 32'd0);
    check_eq("full_count", {29'd0, o_count},   32'd4);
    check_eq("full_pc",    {16'd0, o_pc},      32'h0000);
    check_eq("full_ir",    {16'd0, o_ir},      32'h5A3C);

    // single pop while full: no request in the pop cycle
    i_take = 1'b1;
    #1;
    check_eq("pop_cyc_req", {31'd0, o_mem_req}, 32'd0);
    tick();
    i_take = 1'b0;
    #1;
    check_eq("after_pop_pc",    {16'd0, o_pc},      32'h0001);
    check_eq("after_pop_count", {29'd0, o_count},   32'd3);
    check_eq("after_pop_req",   {31'd0, o_mem_req}, 32'd1);
    check_eq("after_pop_adr",   {16'd0, o_mem_adr}, 32'h0004);
    tick();

    // steady state: queue holds 1..4, fetch_pc=5; first pop drops to 3
    i_take = 1'b1;
    #1;
    check_eq("ss_head", {16'd0, o_pc}, 32'h0001);
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("ss_pc",    {16'd0, o_pc},      32'(2 + k));
      check_eq("ss_ir",    {16'd0, o_ir},      {16'd0, word(16'(2 + k))});
      check_eq("ss_count", {29'd0, o_count},   32'd3);
      check_eq("ss_adr",   {16'd0, o_mem_adr}, 32'(5 + k));
      tick();
    end

    // redirect to 0x0040 with 3 entries queued and rdy=1
    i_take        = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 16'h0040;
    #1;
    check_eq("redir_count_before", {29'd0, o_count},   32'd3);
    check_eq("redir_cyc_req",      {31'd0, o_mem_req}, 32'd0);
    tick();
    i_redirect = 1'b0;
    i_mem_rdy  = 1'b0;
    #1;
    check_eq("redir_valid", {31'd0, o_valid},   32'd0);
    check_eq("redir_count", {29'd0, o_count},   32'd0);
    check_eq("redir_adr",   {16'd0, o_mem_adr}, 32'h0040);
    tick();
    i_mem_rdy = 1'b1;
    #1;
    check_eq("redir_req", {31'd0, o_mem_req}, 32'd1);
    tick();
    #1;
    check_eq("redir_first_valid", {31'd0, o_valid}, 32'd1);
    check_eq("redir_first_pc",    {16'd0, o_pc},    32'h0040);
    check_eq("redir_first_ir",    {16'd0, o_ir},    {16'd0, word(16'h0040)});
    tick();

    // halt with 2 entries (0x40, 0x41) queued
    i_halt    = 1'b1;
    i_mem_rdy = 1'b0;
    tick();
    i_halt    = 1'b0;
    i_mem_rdy = 1'b1;
    i_take    = 1'b1;
    #1;
    check_eq("halt_flag",  {31'd0, o_halted},  32'd1);
    check_eq("halt_req",   {31'd0, o_mem_req}, 32'd0);
    check_eq("halt_count", {29'd0, o_count},   32'd2);
    check_eq("halt_pc0",   {16'd0, o_pc},      32'h0040);
    tick();
    #1;
    check_eq("halt_pc1", {16'd0, o_pc}, 32'h0041);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("halt_drained_valid", {31'd0, o_valid},   32'd0);
      check_eq("halt_drained_count", {29'd0, o_count},   32'd0);
      check_eq("halt_drained_req",   {31'd0, o_mem_req}, 32'd0);
      tick();
    end

    // redirect releases halt
    i_take        = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 16'h0010;
    tick();
    i_redirect = 1'b0;
    #1;
    check_eq("resume_halted", {31'd0, o_halted},  32'd0);
    check_eq("resume_adr",    {16'd0, o_mem_adr}, 32'h0010);
    check_eq("resume_req",    {31'd0, o_mem_req}, 32'd1);
    tick();
    #1;
    check_eq("resume_pc", {16'd0, o_pc}, 32'h0010);

    // redirect and halt together: redirect wins; then wrap past 0xFFFF
    i_redirect    = 1'b1;
    i_halt        = 1'b1;
    i_redirect_pc = 16'hFFFE;
    tick();
    i_redirect = 1'b0;
    i_halt     = 1'b0;
    #1;
    check_eq("both_halted", {31'd0, o_halted},  32'd0);
    check_eq("wrap_adr0",   {16'd0, o_mem_adr}, 32'hFFFE);
    check_eq("wrap_valid0", {31'd0, o_valid},   32'd0);
    tick();
    i_mem_rdy = 1'b0;
    #1;
    check_eq("stall_adr", {16'd0, o_mem_adr}, 32'hFFFF);
    check_eq("stall_req", {31'd0, o_mem_req}, 32'd1);
    tick();
    i_mem_rdy = 1'b1;
    #1;
    check_eq("stall_hold_adr",   {16'd0, o_mem_adr}, 32'hFFFF);
    check_eq("stall_hold_count", {29'd0, o_count},   32'd1);
    tick();
    #1;
    check_eq("wrap_adr", {16'd0, o_mem_adr}, 32'h0000);
    tick();
    i_mem_rdy = 1'b0;
    i_take    = 1'b1;
    #1;
    check_eq("wrap_count", {29'd0, o_count}, 32'd3);
    check_eq("wrap_pc0",   {16'd0, o_pc},    32'hFFFE);
    tick();
    #1;
    check_eq("wrap_pc1", {16'd0, o_pc}, 32'hFFFF);
    tick();
    #1;
    check_eq("wrap_pc2", {16'd0, o_pc}, 32'h0000);
    check_eq("wrap_ir2", {16'd0, o_ir}, 32'h5A3C);
    tick();
    i_take = 1'b0;
    #1;
    check_eq("wrap_empty", {31'd0, o_valid}, 32'd0);

    // asynchronous reset mid-operation
    i_mem_rdy = 1'b1;
    tick();
    tick();
    #2;
    a_rst = 1'b0;
    #1;
    check_eq("midrst_count", {29'd0, o_count},   32'd0);
    check_eq("midrst_valid", {31'd0, o_valid},   32'd0);
    check_eq("midrst_req",   {31'd0, o_mem_req}, 32'd0);
    check_eq("midrst_adr",   {16'd0, o_mem_adr}, 32'h0000);
    #5;
    a_rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
